// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key schedule and, later, the cipher datapath.
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  localparam int NUM_ROUNDS = 10;

  // Round constants; entry 0 is never used because round 0 is the cipher key itself.
  localparam aes_byte_t RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte-wise left rotate of a word: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  // Table stored MSB-first: entry n lives at bit offset 8*n from the left.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table lookup indexed by the input byte.
  always_comb begin
    sub_val = SBOX_TABLE[{byte_val, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store,
// exposed both flat and through a round-indexed read port for the decryptor.
module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          KS_START,
  input  logic [127:0]  KS_KEY,
  input  logic [3:0]    KS_ROUND_IDX,
  output logic [127:0]  KS_ROUND_KEY,
  output logic [1407:0] KEY_SCHEDULE,
  output logic          KS_BUSY,
  output logic          KS_DONE
);
  import aes_pkg::*;

  if (NUM_ROUNDS != 10) begin : g_illegal_rounds
    $error("aes_key_expander supports AES-128 only (NUM_ROUNDS must be 10)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_t state_r;
  logic [3:0] cnt_r;
  logic       start_q_r;
  logic       busy_r;
  logic       done_r;
  aes_key_t   key_store_r [0:NUM_ROUNDS];

  logic       start_pulse_s;
  aes_key_t   prev_key_s;
  aes_byte_t  rcon_s;
  aes_word_t  rot_s;
  aes_word_t  sub_s;
  aes_word_t  temp_s;
  aes_word_t  w0_s, w1_s, w2_s, w3_s;
  aes_key_t   next_key_s;

  assign start_pulse_s = KS_START & ~start_q_r;

  // Previous round key and round constant; guarded so an idle counter never indexes out of range.
  always_comb begin
    if ((cnt_r >= 4'd1) && (cnt_r <= LAST_ROUND)) begin
      prev_key_s = key_store_r[cnt_r - 4'd1];
      rcon_s     = RCON[cnt_r];
    end else begin
      prev_key_s = 128'd0;
      rcon_s     = 8'h00;
    end
  end

  assign rot_s = rot_word(prev_key_s[31:0]);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .byte_val (rot_s[8*b +: 8]),
      .sub_val  (sub_s[8*b +: 8])
    );
  end

  // One key-schedule round: chained XOR of the previous words with the transformed last word.
  always_comb begin
    temp_s     = sub_s ^ {rcon_s, 24'h000000};
    w0_s       = prev_key_s[127:96] ^ temp_s;
    w1_s       = prev_key_s[95:64]  ^ w0_s;
    w2_s       = prev_key_s[63:32]  ^ w1_s;
    w3_s       = prev_key_s[31:0]   ^ w2_s;
    next_key_s = {w0_s, w1_s, w2_s, w3_s};
  end

  // Control FSM, start-edge detector, key store and registered status flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      start_q_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        key_store_r[i] <= 128'd0;
      end
    end else begin
      start_q_r <= KS_START;
      case (state_r)
        IDLE, DONE: begin
          if (start_pulse_s) begin
            key_store_r[0] <= KS_KEY;
            cnt_r          <= 4'd1;
            state_r        <= EXPAND;
            busy_r         <= 1'b1;
            done_r         <= 1'b0;
          end
        end
        EXPAND: begin
          // Start edges here are deliberately ignored; the running key is already latched.
          key_store_r[cnt_r] <= next_key_s;
          if (cnt_r == LAST_ROUND) begin
            cnt_r   <= 4'd0;
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          cnt_r   <= 4'd0;
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Round-indexed read port; indices beyond the last round read as zero.
  always_comb begin
    if (KS_ROUND_IDX <= LAST_ROUND) begin
      KS_ROUND_KEY = key_store_r[KS_ROUND_IDX];
    end else begin
      KS_ROUND_KEY = 128'd0;
    end
  end

  for (genvar r = 0; r <= NUM_ROUNDS; r++) begin : g_flat
    assign KEY_SCHEDULE[1407 - 128*r -: 128] = key_store_r[r];
  end

  assign KS_BUSY = busy_r;
  assign KS_DONE = done_r;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: expected schedules come from an independent
// software model (S-box derived from GF(2^8) inversion) and are queued at start time.
module tb_aes_key_expander;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          KS_START;
  logic [127:0]  KS_KEY;
  logic [3:0]    KS_ROUND_IDX;
  logic [127:0]  KS_ROUND_KEY;
  logic [1407:0] KEY_SCHEDULE;
  logic          KS_BUSY;
  logic          KS_DONE;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]    sbox_tab [0:255];
  logic [1407:0] exp_q [$];

  localparam logic [127:0] KEY1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY1_1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KEY1_X = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2_X = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_key_expander #(.NUM_ROUNDS(10)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .KS_START     (KS_START),
    .KS_KEY       (KS_KEY),
    .KS_ROUND_IDX (KS_ROUND_IDX),
    .KS_ROUND_KEY (KS_ROUND_KEY),
    .KEY_SCHEDULE (KEY_SCHEDULE),
    .KS_BUSY      (KS_BUSY),
    .KS_DONE      (KS_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15 - n -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] model_expand(input logic [127:0] key);
    logic [1407:0] sched;
    logic [127:0]  k = key;
    logic [7:0]    rc = 8'h01;
    logic [31:0]   t, w0, w1, w2, w3;
    sched[1407 -: 128] = key;
    for (int r = 1; r <= 10; r++) begin
      t  = {sbox_tab[k[23:16]], sbox_tab[k[15:8]], sbox_tab[k[7:0]], sbox_tab[k[31:24]]};
      t  = t ^ {rc, 24'h000000};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      k  = {w0, w1, w2, w3};
      sched[1407 - 128*r -: 128] = k;
      rc = xtime(rc);
    end
    return sched;
  endfunction

  // Drive a start, optionally inject a second start edge mid-expansion, and measure latency.
  task automatic run_exp(input logic [127:0] key, input int hold, input int inject_at,
                         input logic [127:0] inject_key);
    int lat = -1;
    @(negedge CLK);
    KS_KEY = key;
    KS_START = 1'b1;
    exp_q.push_back(model_expand(key));
    for (int k = 0; k <= 40; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (k + 1 >= hold) KS_START = 1'b0;
      if (k == 0) KS_KEY = ~key;
      if (inject_at > 0 && k == inject_at - 1) begin
        KS_START = 1'b1;
        KS_KEY = inject_key;
      end
      if (inject_at > 0 && k == inject_at) KS_START = 1'b0;
      if (KS_DONE) begin
        lat = k;
        break;
      end
      check($sformatf("busy_t%0d", k), 128'(KS_BUSY), 128'd1);
    end
    KS_START = 1'b0;
    check("latency", 128'(lat), 128'd10);
    check("busy_after_done", 128'(KS_BUSY), 128'd0);
  endtask

  // Pop the expected schedule and compare both read paths round by round.
  task automatic verify_sched();
    logic [1407:0] expv;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 128'd1, 128'd0);
      return;
    end
    expv = exp_q.pop_front();
    for (int i = 0; i <= 10; i++) begin
      KS_ROUND_IDX = 4'(i);
      #1;
      check($sformatf("round_key_%0d", i), KS_ROUND_KEY, expv[1407 - 128*i -: 128]);
      check($sformatf("flat_%0d", i), KEY_SCHEDULE[1407 - 128*i -: 128], expv[1407 - 128*i -: 128]);
    end
  endtask

  task automatic check_idx(input string tag, input int idx, input logic [127:0] expv);
    KS_ROUND_IDX = 4'(idx);
    #1;
    check(tag, KS_ROUND_KEY, expv);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 128'(KS_BUSY), 128'd0);
    check({tag, "_done"}, 128'(KS_DONE), 128'd0);
    for (int i = 0; i <= 10; i++) begin
      check($sformatf("%s_flat_%0d", tag, i), KEY_SCHEDULE[1407 - 128*i -: 128], 128'd0);
    end
  endtask

  initial begin
    RESET = 1'b1;
    KS_START = 1'b0;
    KS_KEY = 128'd0;
    KS_ROUND_IDX = 4'd0;
    build_sbox();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_cleared("reset");
    check_idx("reset_idx5", 5, 128'd0);
    RESET = 1'b0;

    // Test 1: reference key, single-cycle start.
    run_exp(KEY1, 1, 0, 128'd0);
    verify_sched();
    check_idx("t1_idx0", 0, KEY1);
    check_idx("t1_idx1", 1, KEY1_1);
    check_idx("t1_idx10", 10, KEY1_X);

    // Test 2: start held two cycles counts once; done stays high afterwards.
    run_exp(KEY2, 2, 0, 128'd0);
    repeat (3) @(negedge CLK);
    check("t2_done_held", 128'(KS_DONE), 128'd1);
    check("t2_flat_last", KEY_SCHEDULE[127:0], KEY2_X);
    verify_sched();

    // Test 3: second start edge during expansion with another key is ignored.
    run_exp(KEY1, 1, 4, KEY2);
    verify_sched();
    check_idx("t3_idx10", 10, KEY1_X);

    // Test 4: reset mid-expansion aborts and clears everything immediately.
    @(negedge CLK);
    KS_KEY = KEY2;
    KS_START = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    KS_START = 1'b0;
    RESET = 1'b1;
    #1;
    check_cleared("t4_abort");
    @(negedge CLK);
    RESET = 1'b0;
    run_exp(KEY1, 1, 0, 128'd0);
    verify_sched();
    check_idx("t4_idx10", 10, KEY1_X);

    // Test 5: back-to-back restarts from DONE, then out-of-range reads.
    run_exp(KEY2, 1, 0, 128'd0);
    verify_sched();
    check_idx("t5_idx10_k2", 10, KEY2_X);
    run_exp(KEY1, 1, 0, 128'd0);
    verify_sched();
    check_idx("t5_idx1_k1", 1, KEY1_1);
    for (int i = 11; i <= 15; i++) begin
      check_idx($sformatf("t5_idx%0d_zero", i), i, 128'd0);
    end

    // Test 6: random keys against the model.
    for (int n = 0; n < 32; n++) begin
      run_exp({$urandom, $urandom, $urandom, $urandom}, 1, 0, 128'd0);
      verify_sched();
    end

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
